// File: rtl/lfsr1_pkg.sv
// lfsr1_pkg: definitions shared by the 16-bit LFSR generator and checker.
//   LFSR_W          register width
//   TAP_A..TAP_D    feedback tap positions (15, 12, 5, 0)
//   chk_state_t     checker state encoding (HUNT, SYNC, LOCKED)
//   lfsr_fb()       feedback bit for a register word; the new bit enters at the LSB
package lfsr1_pkg;

    localparam int LFSR_W = 16;
    localparam int TAP_A  = 15;
    localparam int TAP_B  = 12;
    localparam int TAP_C  = 5;
    localparam int TAP_D  = 0;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr1_chk_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear.
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   clear   clears the count; when inc is also high the result is 1
//   inc     count up by one, holding at all-ones
//   count   current count, W bits
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr1_chk.sv
// lfsr1_chk: self-synchronising serial checker for the 16-bit LFSR stream
// (taps 15,12,5,0; new bit at the LSB).
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_valid   qualifies in_bit; nothing advances while low
//   in_bit     received stream bit
//   clear_cnt  synchronous clear of err_count
//   locked     registered: checker is in LOCKED
//   err_pulse  one-cycle pulse for a mismatch accepted while LOCKED
//   rx_state   (only with LFSR1_CHK_STATE_OUT_EN) history word while LOCKED, else 0
//   err_count  saturating count of LOCKED-state mismatches
// Optional feature macro: LFSR1_CHK_STATE_OUT_EN.
module lfsr1_chk
    import lfsr1_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              err_pulse,
`ifdef LFSR1_CHK_STATE_OUT_EN
    output logic [LFSR_W-1:0] rx_state,
`endif
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [7:0] LOCK_M1 = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_M1 = 8'(LOSS_CNT - 1);

    chk_state_t        state;
    logic [LFSR_W-1:0] hist;
    logic [4:0]        fill;
    logic [7:0]        match;
    logic [7:0]        miss;

    logic pred;
    logic hit;
    logic hist_nz;
    logic err_inc;

    always_comb begin
        pred    = lfsr_fb(hist);
        hit     = (in_bit == pred);
        hist_nz = |hist;
        err_inc = in_valid && (state == LOCKED) && !hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= HUNT;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
`ifdef LFSR1_CHK_STATE_OUT_EN
            rx_state  <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        hist <= {hist[LFSR_W-2:0], in_bit};
                        fill <= fill + 5'd1;
                        if (fill == 5'(LFSR_W - 1)) begin
                            state <= SYNC;
                            match <= '0;
                        end
                    end
                    SYNC: begin
                        hist <= {hist[LFSR_W-2:0], in_bit};
                        // An all-zero history would predict 0 forever; treat it as a miss.
                        if (hit && hist_nz) begin
                            match <= match + 8'd1;
                            if (match == LOCK_M1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                miss   <= '0;
`ifdef LFSR1_CHK_STATE_OUT_EN
                                rx_state <= {hist[LFSR_W-2:0], in_bit};
`endif
                            end
                        end else begin
                            match <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the prediction, not the received bit, feeds the history.
                        hist <= {hist[LFSR_W-2:0], pred};
`ifdef LFSR1_CHK_STATE_OUT_EN
                        rx_state <= {hist[LFSR_W-2:0], pred};
`endif
                        if (!hit) begin
                            err_pulse <= 1'b1;
                            if (miss == LOSS_M1) begin
                                state  <= HUNT;
                                fill   <= '0;
                                miss   <= '0;
                                locked <= 1'b0;
`ifdef LFSR1_CHK_STATE_OUT_EN
                                rx_state <= '0;
`endif
                            end else begin
                                miss <= miss + 8'd1;
                            end
                        end else begin
                            miss <= '0;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        fill  <= '0;
                    end
                endcase
            end
        end
    end

    sat_cnt #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (clear_cnt),
        .inc    (err_inc),
        .count  (err_count)
    );

endmodule

// File: tb/tb_lfsr1_chk.sv
// tb_lfsr1_chk: bench for lfsr1_chk. Two instances share the stimulus:
//   dut_m  default parameters (LOCK 32, LOSS 8, 16-bit count)
//   dut_a  LOSS 255 with a 4-bit count so saturation is reachable quickly
module tb_lfsr1_chk;

    localparam int LOCK = 32;
    localparam int LOSS_A [2] = '{8, 255};
    localparam int CMAX_A [2] = '{65535, 15};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic clear_cnt = 1'b0;

    logic        locked_m, pulse_m, locked_a, pulse_a;
    logic [15:0] cnt_m;
    logic [3:0]  cnt_a;
`ifdef LFSR1_CHK_STATE_OUT_EN
    logic [15:0] rx_m, rx_a;
`endif

    always #5 clk = ~clk;

    lfsr1_chk dut_m (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_cnt (clear_cnt),
        .locked    (locked_m),
        .err_pulse (pulse_m),
`ifdef LFSR1_CHK_STATE_OUT_EN
        .rx_state  (rx_m),
`endif
        .err_count (cnt_m)
    );

    lfsr1_chk #(
        .LOCK_CNT (32),
        .LOSS_CNT (255),
        .CNT_W    (4)
    ) dut_a (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_cnt (clear_cnt),
        .locked    (locked_a),
        .err_pulse (pulse_a),
`ifdef LFSR1_CHK_STATE_OUT_EN
        .rx_state  (rx_a),
`endif
        .err_count (cnt_a)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference generator: the transmit LFSR, seeded 16'hACE1.
    logic [15:0] g;
    task automatic gen_bit(output bit b);
        b = g[15] ^ g[12] ^ g[5] ^ g[0];
        g = {g[14:0], b};
    endtask

    // Behavioural checker model: bit history x[n-1..n-16] as a list, mode
    // as a small integer, counters as plain ints.
    int mode [2];   // 0 hunt, 1 sync, 2 locked
    int fill [2];
    int mt   [2];
    int ms   [2];
    int cn   [2];
    bit lk   [2];
    bit pu   [2];
    bit xb   [2][16];   // xb[i][k] = x[n-1-k]

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; fill[i] = 0; mt[i] = 0; ms[i] = 0; cn[i] = 0;
            lk[i] = 0; pu[i] = 0;
            for (int k = 0; k < 16; k++) xb[i][k] = 0;
        end
    endtask

    task automatic push(input int i, input bit b);
        for (int k = 15; k > 0; k--) xb[i][k] = xb[i][k-1];
        xb[i][0] = b;
    endtask

    task automatic model_step(input int i, input bit v, input bit b, input bit c);
        bit p;
        int ones;
        bit counted;
        counted = 0;
        pu[i] = 0;
        if (v) begin
            // x[n] = x[n-16] ^ x[n-13] ^ x[n-6] ^ x[n-1]
            p = xb[i][15] ^ xb[i][12] ^ xb[i][5] ^ xb[i][0];
            ones = 0;
            for (int k = 0; k < 16; k++) ones += int'(xb[i][k]);
            if (mode[i] == 0) begin
                push(i, b);
                fill[i]++;
                if (fill[i] == 16) begin mode[i] = 1; mt[i] = 0; end
            end else if (mode[i] == 1) begin
                if (b == p && ones != 0) mt[i]++; else mt[i] = 0;
                push(i, b);
                if (mt[i] == LOCK) begin mode[i] = 2; lk[i] = 1; ms[i] = 0; end
            end else begin
                push(i, p);
                if (b != p) begin
                    pu[i] = 1; counted = 1; ms[i]++;
                    if (ms[i] == LOSS_A[i]) begin
                        mode[i] = 0; fill[i] = 0; ms[i] = 0; lk[i] = 0;
                    end
                end else begin
                    ms[i] = 0;
                end
            end
        end
        if (c) cn[i] = counted ? 1 : 0;
        else if (counted && cn[i] < CMAX_A[i]) cn[i]++;
    endtask

    task automatic compare_all();
        check("m.locked", 32'(locked_m), 32'(lk[0]));
        check("m.err_pulse", 32'(pulse_m), 32'(pu[0]));
        check("m.err_count", 32'(cnt_m), 32'(cn[0]));
        check("a.locked", 32'(locked_a), 32'(lk[1]));
        check("a.err_pulse", 32'(pulse_a), 32'(pu[1]));
        check("a.err_count", 32'(cnt_a), 32'(cn[1]));
`ifdef LFSR1_CHK_STATE_OUT_EN
        check("m.rx_state", 32'(rx_m), lk[0] ? 32'(g) : 32'd0);
`endif
    endtask

    task automatic cyc(input bit v, input bit b, input bit c);
        in_valid  = v;
        in_bit    = b;
        clear_cnt = c;
        @(posedge clk);
        #1;
        model_step(0, v, b, c);
        model_step(1, v, b, c);
        compare_all();
    endtask

    // One cycle; valid bits come from the generator, optionally inverted.
    task automatic send(input bit v, input bit flip, input bit clr);
        bit b;
        if (v) begin
            gen_bit(b);
            b = b ^ flip;
        end else begin
            b = 1'($urandom);
        end
        cyc(v, b, clr);
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_cnt = 1'b0;
        g = 16'hACE1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        int n;
        bit flip;
        bit clr;
        bit exp_locked;
        bit exp_pulse;
        int exp_cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{47,    1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1,     1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2]  = '{10000, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{1,     1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[4]  = '{1,     1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[5]  = '{1,     1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[6]  = '{7,     1'b1, 1'b0, 1'b1, 1'b1, 7};
        tbl[7]  = '{1,     1'b1, 1'b0, 1'b0, 1'b1, 8};
        tbl[8]  = '{47,    1'b0, 1'b0, 1'b0, 1'b0, 8};
        tbl[9]  = '{1,     1'b0, 1'b0, 1'b1, 1'b0, 8};
        tbl[10] = '{3,     1'b1, 1'b0, 1'b1, 1'b1, 11};

        // Reset values and table-driven lock / error / loss / relock
        do_reset();
        for (int t = 0; t < 11; t++) begin
            for (int k = 0; k < tbl[t].n; k++) send(1'b1, tbl[t].flip, tbl[t].clr);
            check($sformatf("tbl%0d.locked", t), 32'(locked_m), 32'(tbl[t].exp_locked));
            check($sformatf("tbl%0d.err_pulse", t), 32'(pulse_m), 32'(tbl[t].exp_pulse));
            check($sformatf("tbl%0d.err_count", t), 32'(cnt_m), 32'(tbl[t].exp_cnt));
        end

        // Randomised traffic while locked: sporadic gaps, flips and clears
        for (int k = 0; k < 3000; k++) begin
            send(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 200) == 0);
        end

        // Dead line: constant zero never locks and never counts
        do_reset();
        begin
            bit ever;
            ever = 0;
            for (int k = 0; k < 1000; k++) begin
                cyc(1'b1, 1'b0, 1'b0);
                if (locked_m) ever = 1;
            end
            check("zero.ever_locked", 32'(ever), 32'd0);
            check("zero.err_count", 32'(cnt_m), 32'd0);
        end

        // Gapped acquisition: lock follows the 48th valid bit
        do_reset();
        begin
            int nv;
            int guard;
            nv = 0;
            guard = 0;
            while (nv < 48 && guard < 2000) begin
                bit v;
                v = 1'($urandom);
                send(v, 1'b0, 1'b0);
                if (v) begin
                    nv++;
                    if (nv == 47) check("gap.locked_at_47", 32'(locked_m), 32'd0);
                end
                guard++;
            end
            check("gap.valid_bits", 32'(nv), 32'd48);
            check("gap.locked_at_48", 32'(locked_m), 32'd1);
            repeat (5) send(1'b0, 1'b0, 1'b0);
            check("gap.locked_hold", 32'(locked_m), 32'd1);
        end

        // Saturation on the wide-loss instance, clear with a coincident error,
        // then asynchronous reset mid-lock
        do_reset();
        repeat (48) send(1'b1, 1'b0, 1'b0);
        repeat (20) send(1'b1, 1'b1, 1'b0);
        check("sat.a_count", 32'(cnt_a), 32'd15);
        check("sat.a_locked", 32'(locked_a), 32'd1);
        check("sat.m_count", 32'(cnt_m), 32'd8);
        check("sat.m_locked", 32'(locked_m), 32'd0);
        send(1'b1, 1'b1, 1'b1);
        check("clr_inc.a_count", 32'(cnt_a), 32'd1);
        check("clr_inc.m_count", 32'(cnt_m), 32'd0);
        send(1'b1, 1'b1, 1'b0);
        check("pre_rst.a_pulse", 32'(pulse_a), 32'd1);
        check("pre_rst.a_count", 32'(cnt_a), 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        check("arst.a_locked", 32'(locked_a), 32'd0);
        check("arst.a_pulse", 32'(pulse_a), 32'd0);
        check("arst.a_count", 32'(cnt_a), 32'd0);
        check("arst.m_locked", 32'(locked_m), 32'd0);
        check("arst.m_count", 32'(cnt_m), 32'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
